acc_norm_unit_pipe: RTL and testbench

Post-accumulation normalizer. It takes the signed, exponent-aligned mantissa sum produced downstream of the 4-input exponent compare/align stage, together with the shared max exponent, and returns sign, normalized exponent and truncated fraction. Sits between the PE adder tree and the output/accumulator register. Implemented as a 3-stage elastic pipeline with valid/ready handshake on both sides.

---
 rtl/acc_norm_unit_pipe.sv | 136 +++++++++++++
 tb/tb_acc_norm_unit_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_norm_unit_pipe.sv
// Post-accumulation normalizer: |sum| -> leading-one detect -> shift/exponent adjust.
// Three-register elastic pipeline; the S3 registers drive the outputs directly.
module acc_norm_unit_pipe #(
  parameter int EXP_WIDTH = 11,
  parameter int SUM_WIDTH = 32,
  parameter int MAN_WIDTH = 23,
  parameter int HID_POS   = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_WIDTH-1:0] isum,
  input  logic [EXP_WIDTH-1:0] iexp_max,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 osign,
  output logic [EXP_WIDTH-1:0] oexp,
  output logic [MAN_WIDTH-1:0] oman,
  output logic                 ozero,
  output logic                 oovf,
  output logic                 ounf
);
  localparam int STAGES = 3;
  localparam int LW     = $clog2(SUM_WIDTH);
  localparam int EW     = EXP_WIDTH + 2;
  localparam logic [LW-1:0]        MAN_L = LW'(MAN_WIDTH);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EW-1:0] HID_E = EW'(HID_POS);

  typedef struct packed {
    logic                 sign;
    logic [SUM_WIDTH-1:0] mag;
    logic [EXP_WIDTH-1:0] exp;
  } s1_t;

  typedef struct packed {
    logic                 sign;
    logic [SUM_WIDTH-1:0] mag;
    logic [EXP_WIDTH-1:0] exp;
    logic [LW-1:0]        lead;
    logic                 zero;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic [STAGES:1] adv;
  s1_t s1;
  s2_t s2;

  // a stage may take a new beat when it is empty or its content is moving on
  assign adv[3]    = !vld_pipe[3] || out_ready;
  assign adv[2]    = !vld_pipe[2] || adv[3];
  assign adv[1]    = !vld_pipe[1] || adv[2];
  assign in_ready  = adv[1];
  assign out_valid = vld_pipe[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      if (adv[1]) vld_pipe[1] <= in_valid;
      if (adv[2]) vld_pipe[2] <= vld_pipe[1];
      if (adv[3]) vld_pipe[3] <= vld_pipe[2];
    end
  end

  // S1: sign/magnitude split; negating the most negative value yields 2^(W-1) unsigned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else if (in_valid && adv[1]) begin
      s1.sign <= isum[SUM_WIDTH-1];
      s1.mag  <= isum[SUM_WIDTH-1] ? (~isum + 1'b1) : isum;
      s1.exp  <= iexp_max;
    end
  end

  // S2: leading-one position
  logic [LW-1:0] lead;
  always_comb begin
    lead = '0;
    for (int i = 0; i < SUM_WIDTH; i++)
      if (s1.mag[i]) lead = LW'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2 <= '0;
    end else if (vld_pipe[1] && adv[2]) begin
      s2.sign <= s1.sign;
      s2.mag  <= s1.mag;
      s2.exp  <= s1.exp;
      s2.lead <= lead;
      s2.zero <= (s1.mag == '0);
    end
  end

  // S3: normalize shift and exponent, computed wide enough never to wrap
  logic signed [EW-1:0]  e;
  logic [MAN_WIDTH-1:0]  frac;
  always_comb begin
    e = signed'(EW'(s2.exp)) + signed'(EW'(s2.lead)) - HID_E;
    if (s2.lead >= MAN_L) frac = MAN_WIDTH'(s2.mag >> (s2.lead - MAN_L));
    else                  frac = MAN_WIDTH'(s2.mag << (MAN_L - s2.lead));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      osign <= 1'b0;
      oexp  <= '0;
      oman  <= '0;
      ozero <= 1'b0;
      oovf  <= 1'b0;
      ounf  <= 1'b0;
    end else if (vld_pipe[2] && adv[3]) begin
      osign <= s2.sign;
      oexp  <= '0;
      oman  <= '0;
      ozero <= 1'b0;
      oovf  <= 1'b0;
      ounf  <= 1'b0;
      if (s2.zero) begin
        osign <= 1'b0;
        ozero <= 1'b1;
      end else if (e >= EMAX) begin
        oovf <= 1'b1;
        oexp <= '1;
      end else if (e <= 0) begin
        ounf <= 1'b1;
      end else begin
        oexp <= e[EXP_WIDTH-1:0];
        oman <= frac;
      end
    end
  end
endmodule

// File: tb/tb_acc_norm_unit_pipe.sv
// Bench for acc_norm_unit_pipe: arithmetic reference model + scoreboard,
// directed beats with literal expectations, streaming, backpressure and reset.
module tb_acc_norm_unit_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] isum;
  logic [10:0] iexp_max, oexp;
  logic [22:0] oman;
  logic        osign, ozero, oovf, ounf;

  acc_norm_unit_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .isum(isum), .iexp_max(iexp_max), .out_valid(out_valid), .out_ready(out_ready),
    .osign(osign), .oexp(oexp), .oman(oman), .ozero(ozero), .oovf(oovf), .ounf(ounf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [10:0] exp;
    logic [22:0] man;
    logic        zero, ovf, unf;
  } res_t;

  res_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // value = s * 2^(x-23); normalize as m.fff * 2^e with m the leading one
  function automatic res_t model(input logic [31:0] s, input logic [10:0] x);
    res_t r;
    longint v, mag;
    int l, e;
    r = '{sign: 1'b0, exp: '0, man: '0, zero: 1'b0, ovf: 1'b0, unf: 1'b0};
    v = longint'($signed(s));
    mag = (v < 0) ? -v : v;
    if (mag == 0) begin
      r.zero = 1'b1;
      return r;
    end
    l = 0;
    while ((mag >> (l + 1)) != 0) l++;
    e = int'(x) + l - 23;
    r.sign = (v < 0);
    if (e >= 2047) begin
      r.ovf = 1'b1;
      r.exp = 11'h7FF;
    end else if (e <= 0) begin
      r.unf = 1'b1;
    end else begin
      r.exp = e[10:0];
      r.man = 23'(((mag << 23) >> l) & 64'h7F_FFFF);
    end
    return r;
  endfunction

  // compare process: every output-valid cycle against the scoreboard, plus stall stability
  logic        stalled = 1'b0;
  logic [37:0] held;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_data", {osign, oexp, oman, ozero, oovf, ounf}, held);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out: got out_valid=1 expected no pending beat at %0t", $time);
        end else begin
          chk("m_sign", osign, q[0].sign);
          chk("m_exp",  oexp,  q[0].exp);
          chk("m_man",  oman,  q[0].man);
          chk("m_flags", {ozero, oovf, ounf}, {q[0].zero, q[0].ovf, q[0].unf});
          if (out_ready) void'(q.pop_front());
        end
      end
      stalled = out_valid && !out_ready;
      held = {osign, oexp, oman, ozero, oovf, ounf};
      if (in_valid && in_ready) q.push_back(model(isum, iexp_max));
    end
  end

  task automatic send_chk(input string nm, input logic [31:0] s, input logic [10:0] x,
                          input logic es, input logic [10:0] ee, input logic [22:0] em,
                          input logic [2:0] eflags);
    int cyc;
    in_valid = 1'b1; isum = s; iexp_max = x;
    chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_latency"}, cyc, 3);
    chk({nm, "_sign"}, osign, es);
    chk({nm, "_exp"}, oexp, ee);
    chk({nm, "_man"}, oman, em);
    chk({nm, "_flags"}, {ozero, oovf, ounf}, eflags);
    @(posedge clk); #1;
  endtask

  logic [31:0] v5 [6] = '{32'h00C0_0000, 32'hFFFF_F001, 32'h1234_5678,
                          32'h0000_0007, 32'hDEAD_BEEF, 32'h00FF_FFFF};

  initial begin
    int j, budget;
    logic took;
    rst = 1'b1; in_valid = 1'b0; isum = '0; iexp_max = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", {osign, oexp, oman, ozero, oovf, ounf}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    send_chk("t1_one",  32'h0080_0000, 11'd1023, 1'b0, 11'd1023, 23'h0, 3'b000);
    send_chk("t2_neg",  32'hFF00_0000, 11'd1023, 1'b1, 11'd1024, 23'h0, 3'b000);
    send_chk("t2_three", 32'h0000_0003, 11'd1023, 1'b0, 11'd1001, 23'h40_0000, 3'b000);
    send_chk("t3_zero", 32'h0000_0000, 11'd500,  1'b0, 11'd0,    23'h0, 3'b100);
    send_chk("t3_ovf",  32'h4000_0000, 11'd2040, 1'b0, 11'h7FF,  23'h0, 3'b010);
    send_chk("t3_unf",  32'h0000_0001, 11'd10,   1'b0, 11'd0,    23'h0, 3'b001);
    send_chk("t3_minneg", 32'h8000_0000, 11'd100, 1'b1, 11'd108, 23'h0, 3'b000);

    // back-to-back streaming
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        isum = (c * 32'h0001_F3A5) - 32'h0004_0000;
        iexp_max = 11'(200 + c * 50);
        chk("t4_in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      chk("t4_out_valid", out_valid, (c >= 3 && c < 11));
      @(posedge clk); #1;
    end

    // backpressure: only three beats fit while the output is blocked
    out_ready = 1'b0;
    j = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; isum = v5[j]; iexp_max = 11'(1000 + j * 3);
      took = in_ready;
      @(posedge clk); #1;
      if (took) j++;
    end
    chk("t5_accepted", j, 3);
    chk("t5_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    budget = 0;
    while (j < 6 && budget < 50) begin
      in_valid = 1'b1; isum = v5[j]; iexp_max = 11'(1000 + j * 3);
      took = in_ready;
      @(posedge clk); #1;
      if (took) j++;
      budget++;
    end
    in_valid = 1'b0;
    chk("t5_all_accepted", j, 6);
    budget = 0;
    while (q.size() != 0 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("t5_drained", q.size(), 0);

    // reset with two beats in flight
    in_valid = 1'b1; isum = 32'h0080_0000; iexp_max = 11'd500;
    @(posedge clk); #1;
    isum = 32'h00C0_0000; iexp_max = 11'd600;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("t6_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_outs", {osign, oexp, oman, ozero, oovf, ounf}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_chk("t6_post", 32'hFFFF_FFFD, 11'd1023, 1'b1, 11'd1001, 23'h40_0000, 3'b000);
    for (int c = 0; c < 5; c++) begin
      chk("t6_no_ghost", out_valid, 0);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
